// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues one memory read at a time for the current PC
// and buffers {pc, instruction} pairs in a small FIFO for decode.
module fetch_queue #(
  parameter int ADDR_SIZE  = 32,
  parameter int INSTR_SIZE = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_SIZE-1:0]  pc,
  input  logic                  redirect,
  output logic                  pcStall,
  output logic                  memReqValid,
  output logic [ADDR_SIZE-1:0]  memReqAddr,
  input  logic                  memReqReady,
  input  logic                  memRespValid,
  input  logic [INSTR_SIZE-1:0] memRespData,
  output logic                  instrValid,
  output logic [INSTR_SIZE-1:0] instrData,
  output logic [ADDR_SIZE-1:0]  instrPc,
  input  logic                  instrReady
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE-1:0]  req_pc_q, req_pc_d;
  logic [INSTR_SIZE-1:0] data_q [DEPTH];
  logic [INSTR_SIZE-1:0] data_d [DEPTH];
  logic [ADDR_SIZE-1:0]  pc_q [DEPTH];
  logic [ADDR_SIZE-1:0]  pc_d [DEPTH];
  logic                  fire;
  logic                  push;
  logic                  pop;

  assign memReqValid = (state_q == REQ);
  assign memReqAddr  = pc;
  assign fire        = memReqValid & memReqReady;
  assign pcStall     = ~fire;
  assign instrValid  = (count_q != '0);
  assign instrData   = data_q[rd_ptr_q];
  assign instrPc     = pc_q[rd_ptr_q];

  // A redirect cancels any same-cycle push or pop
  assign push = (state_q == WAIT) & memRespValid & ~redirect;
  assign pop  = instrValid & instrReady & ~redirect;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    pc_d     = pc_q;
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = memRespData;
        pc_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Requests are credit-gated on the post-update count, so a pop unblocks REQ next cycle
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      IDLE: begin
        if (count_d < FULL) state_d = REQ;
      end
      REQ: begin
        if (memReqReady) begin
          req_pc_d = pc;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_d = memRespValid ? IDLE : DROP;
        end else if (memRespValid) begin
          state_d = (count_d < FULL) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (memRespValid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      req_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      req_pc_q <= req_pc_d;
      data_q   <= data_d;
      pc_q     <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic,
// all compared against a transaction-level model of the fetch stream.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        redirect;
  logic        pcStall;
  logic        memReqValid;
  logic [31:0] memReqAddr;
  logic        memReqReady;
  logic        memRespValid;
  logic [31:0] memRespData;
  logic        instrValid;
  logic [31:0] instrData;
  logic [31:0] instrPc;
  logic        instrReady;

  fetch_queue #(.ADDR_SIZE(32), .INSTR_SIZE(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc(pc), .redirect(redirect), .pcStall(pcStall),
    .memReqValid(memReqValid), .memReqAddr(memReqAddr), .memReqReady(memReqReady),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .instrValid(instrValid), .instrData(instrData), .instrPc(instrPc),
    .instrReady(instrReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  // Reference model: delivered-instruction queue plus one-outstanding-request bookkeeping
  entry_t      fifo[$];
  logic [31:0] obsPcs[$];
  bit          mReqValid;
  bit          mOut;
  bit          mStale;
  logic [31:0] mReqPc;
  logic [31:0] curPc;
  int          checkCount = 0;
  int          failCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    fifo.delete();
    mReqValid = 1'b0;
    mOut      = 1'b0;
    mStale    = 1'b0;
    mReqPc    = '0;
  endtask

  // Entered at posedge+1; returns at posedge+1 of the following cycle
  task automatic applyStimulus(input bit rd, input logic [31:0] newPc, input bit rdy,
                               input bit rv, input logic [31:0] rdata, input bit ir);
    bit fire, resp, popped, nextReq;
    entry_t e;
    if (rd) curPc = newPc;
    redirect     = rd;
    pc           = curPc;
    memReqReady  = rdy;
    memRespValid = rv & mOut;
    memRespData  = rdata;
    instrReady   = ir;
    #3;
    checkOutput("memReqValid", memReqValid, mReqValid);
    checkOutput("pcStall", pcStall, !(mReqValid && rdy));
    if (mReqValid) checkOutput("memReqAddr", memReqAddr, curPc);
    checkOutput("instrValid", instrValid, fifo.size() != 0);
    if (fifo.size() != 0) begin
      checkOutput("instrPc", instrPc, fifo[0].pc);
      checkOutput("instrData", instrData, fifo[0].data);
    end
    if (instrValid && ir) obsPcs.push_back(instrPc);

    fire   = mReqValid && rdy;
    resp   = rv && mOut;
    popped = (fifo.size() != 0) && ir;
    if (rd) begin
      fifo.delete();
    end else begin
      if (popped) void'(fifo.pop_front());
      if (resp && !mStale) begin
        e.pc   = mReqPc;
        e.data = rdata;
        fifo.push_back(e);
      end
    end
    if (mReqValid)          nextReq = !fire;
    else if (mOut && !resp) nextReq = 1'b0;
    else if (mOut)          nextReq = !mStale && !rd && (fifo.size() < DEPTH);
    else                    nextReq = rd || (fifo.size() < DEPTH);
    if (fire)                       mStale = 1'b0;
    else if (mOut && !resp && rd)   mStale = 1'b1;
    else if (resp)                  mStale = 1'b0;
    if (fire)      mOut = 1'b1;
    else if (resp) mOut = 1'b0;
    if (fire) begin
      mReqPc = curPc;
      curPc  = curPc + 32'd4;
    end
    mReqValid = nextReq;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input logic [31:0] startPc);
    reset        = 1'b1;
    curPc        = startPc;
    pc           = startPc;
    redirect     = 1'b0;
    memReqReady  = 1'b0;
    memRespValid = 1'b0;
    memRespData  = '0;
    instrReady   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
  endtask

  // Scenario sequencing: directed cases first, then randomized traffic
  initial begin
    reset = 1'b1; pc = 32'h100; redirect = 1'b0; memReqReady = 1'b1;
    memRespValid = 1'b0; memRespData = '0; instrReady = 1'b0;
    #2;
    checkOutput("rstMemReqValid", memReqValid, 0);
    checkOutput("rstPcStall", pcStall, 1);
    checkOutput("rstInstrValid", instrValid, 0);
    checkOutput("rstInstrData", instrData, 0);
    checkOutput("rstInstrPc", instrPc, 0);

    // zero-wait memory streaming
    resetDut(32'h100);
    obsPcs.delete();
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 1, 32'hC000_0000 + i, 1);
    checkOutput("zwPopCount", obsPcs.size() >= 3, 1);
    if (obsPcs.size() >= 3) begin
      checkOutput("zwPc0", obsPcs[0], 32'h100);
      checkOutput("zwPc1", obsPcs[1], 32'h104);
      checkOutput("zwPc2", obsPcs[2], 32'h108);
    end

    // fill to DEPTH, then a single pop reopens requests
    resetDut(32'h200);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 1, 32'hF000_0000 + i, 0);
    checkOutput("fullInstrValid", instrValid, 1);
    checkOutput("fullNoReq", memReqValid, 0);
    applyStimulus(0, 0, 1, 0, 0, 1);
    checkOutput("popReopensReq", memReqValid, 1);

    // redirect in WAIT, stale response three cycles later
    resetDut(32'h300);
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(1, 32'h400, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 32'h0000_DEAD, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 32'h1234_0400, 0);
    checkOutput("redirHeadValid", instrValid, 1);
    checkOutput("redirHeadPc", instrPc, 32'h400);
    checkOutput("redirHeadData", instrData, 32'h1234_0400);

    // redirect together with a response in WAIT
    resetDut(32'h500);
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(1, 32'h600, 1, 1, 32'hBAD0_0500, 1);
    checkOutput("redirRespEmpty", instrValid, 0);
    checkOutput("redirRespIdle", memReqValid, 0);
    applyStimulus(0, 0, 1, 0, 0, 1);
    checkOutput("redirRespReq", memReqValid, 1);

    // redirect on the REQ handshake with two entries buffered
    resetDut(32'h700);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1, 32'hA000_0000 + i, 0);
    checkOutput("twoQueued", instrValid, 1);
    applyStimulus(1, 32'h800, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'hABCD_0800, 0);
    checkOutput("hsRedirPc", instrPc, 32'h800);
    checkOutput("hsRedirData", instrData, 32'hABCD_0800);

    // asynchronous reset while WAIT with three entries queued
    resetDut(32'h900);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 1, 32'hB000_0000 + i, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    memReqReady = 1'b1;
    #1 reset = 1'b1;
    #1;
    checkOutput("asyncInstrValid", instrValid, 0);
    checkOutput("asyncMemReqValid", memReqValid, 0);
    checkOutput("asyncPcStall", pcStall, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("asyncResume", memReqValid, 1);

    // randomized traffic against the model
    resetDut(32'h1000);
    for (int i = 0; i < 800; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      applyStimulus(($urandom % 16) == 0, tgt, ($urandom % 3) != 0,
                    ($urandom % 2) == 0, $urandom, ($urandom % 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch stage directly downstream of the branch/PC stage. Takes the current `pc`, issues one memory read per fetch, and buffers returned words with their PC in a DEPTH-entry FIFO for decode. Drives `pcStall` back to the PC stage so the PC advances only when a fetch request is accepted. Flushes its buffer and drops stale responses on a redirect.

## Interface
- `ADDR_SIZE`, 32, width of PC and memory address
- `INSTR_SIZE`, 32, width of instruction word
- `DEPTH`, 4, FIFO entries; power of two, ≥2

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `pc`  in  ADDR_SIZE  fetch address from PC stage; held stable by PC stage while `pcStall`=1
- `redirect`  in  1  PC stage took a non-sequential target this cycle; `pc` already carries the new target
- `pcStall`  out  1  1 = PC stage must hold `pc`
- `memReqValid`  out  1  read request valid
- `memReqAddr`  out  ADDR_SIZE  read address; equals `pc`
- `memReqReady`  in  1  memory accepts request
- `memRespValid`  in  1  read data valid; exactly one response per accepted request, in order
- `memRespData`  in  INSTR_SIZE  read data
- `instrValid`  out  1  FIFO head valid (count ≠ 0)
- `instrData`  out  INSTR_SIZE  FIFO head instruction
- `instrPc`  out  ADDR_SIZE  PC of FIFO head
- `instrReady`  in  1  decode consumes head when `instrValid & instrReady`

## Operation
- FSM states: IDLE, REQ, WAIT, DROP. One outstanding request maximum.
- IDLE: go to REQ when count < DEPTH; else stay.
- REQ: `memReqValid`=1, `memReqAddr`=`pc`. On `memReqReady`: latch `pc` into reqPc, go to WAIT.
- WAIT: on `memRespValid`, push {reqPc, `memRespData`}. Go to REQ if post-update count < DEPTH; else IDLE.
- DROP: on `memRespValid`, discard data, go to IDLE.
- `pcStall` = ~(`memReqValid` & `memReqReady`): combinational; PC advances only in the handshake cycle.
- Pop: `instrValid & instrReady` advances read pointer. Push and pop in the same cycle leave count unchanged. A push at count = DEPTH cannot occur because requests are credit-gated.
- Redirect, highest priority. The FIFO is cleared: count = 0, pointers = 0. Any same-cycle pop or push is cancelled.
  - In WAIT: go to DROP. If `memRespValid` arrives in the same cycle, the response is discarded and the state goes to IDLE.
  - In DROP: stay in DROP.
  - In REQ with handshake: the request uses the new `pc`, which is tagged into reqPc, and the state goes to WAIT. The response is kept.
  - In REQ without handshake, or in IDLE: go to REQ. Redirect clears the FIFO, so space is guaranteed.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits, range 0..DEPTH.

## Timing
- Reset values: state = IDLE, count = 0, pointers = 0, reqPc = 0. `memReqValid`=0, `instrValid`=0, `pcStall`=1, `instrData`/`instrPc` = 0 (storage cleared).
- After reset deasserts: IDLE for 1 cycle, then REQ (`memReqValid`=1).
- Reset asserted mid-operation returns to the reset state immediately. A later response to a pre-reset request is not tracked; memory is reset together with this block.
- `memReqValid` is decoded from registered state only; no combinational path from any input to it.
- Response at cycle N → `instrValid`=1 at N+1 with that entry at head (if FIFO was empty).
- Zero-wait memory (ready and response next cycle): one fetch per 2 cycles (REQ, WAIT).
- FIFO full: no new request until a pop. After the pop, REQ is entered the next cycle.

## Test plan
- Reset then zero-wait memory, `pc`=0x100/0x104/0x108, `instrReady`=1 → `instrPc` 0x100, 0x104, 0x108 in order, each 1 cycle after its response; `pcStall`=0 only in handshake cycles.
- `instrReady`=0, 4 responses → count=4, `memReqValid`=0 with state IDLE; one pop → `memReqValid`=1 the next cycle.
- Redirect in WAIT to `pc`=0x400; stale response 0xDEAD arrives 3 cycles later → 0xDEAD never appears; the next head is data for 0x400 with `instrPc`=0x400.
- Redirect coincident with `memRespValid` in WAIT → response dropped, FIFO empty, REQ follows via IDLE.
- Redirect coincident with REQ handshake on `pc`=0x800, FIFO holding 2 entries → FIFO cleared, the 0x800 response is kept and becomes head.
- Reset pulse mid-WAIT with 3 entries queued → `instrValid`=0, `memReqValid`=0 and `pcStall`=1 immediately (asynchronous); REQ resumes 1 cycle after release.
